piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter that drains a held parallel word onto a single-bit line. It accepts a WIDTH-bit word through a Load/Ready handshake and shifts it out one bit per clock, optionally followed by an even-parity bit. It frames each transfer with Sfrm and reports completion with a one-cycle Done pulse. It sits downstream of the team's level-sensitive storage elements, which write and hold a word, and is the block that reads that word back out.

---
 rtl/piso_serializer.sv | 131 +++++++++++++
 tb/tb_piso_serializer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: frames a held WIDTH-bit word onto Sout,
// optionally followed by an even-parity bit, with a one-cycle Done pulse after each frame.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int PARITY    = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic             Ready,
  output logic             Sout,
  output logic             Sfrm,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int N  = WIDTH + PARITY;
  localparam logic [CW-1:0] LAST_BIT  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  shift_r;
  logic [CW-1:0]     cnt_r;
  logic              par_r;
  logic [WIDTH-1:0]  shifted_s;
  logic              out_bit_s;
  logic              par_nxt_s;

  // Bit at the head of the word in transmission order.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != 0) begin
      head_bit = v[WIDTH-1];
    end else begin
      head_bit = v[0];
    end
  endfunction

  // Even-parity accumulator update with one data bit.
  function automatic logic parity_step(input logic acc, input logic b);
    parity_step = acc ^ b;
  endfunction

  // Next shift-register contents and parity including the bit now on the line.
  always_comb begin
    shifted_s = shift_r;
    out_bit_s = head_bit(shift_r);
    par_nxt_s = par_r;
    if (MSB_FIRST != 0) begin
      shifted_s = shift_r << 1'b1;
    end else begin
      shifted_s = shift_r >> 1'b1;
    end
    if (cnt_r <= LAST_DATA) begin
      par_nxt_s = parity_step(par_r, out_bit_s);
    end else begin
      par_nxt_s = par_r;
    end
  end

  // Transfer FSM with registered handshake and line outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
      par_r   <= 1'b0;
      Ready   <= 1'b1;
      Sout    <= 1'b0;
      Sfrm    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          Done <= 1'b0;
          if (Load) begin
            shift_r <= D;
            cnt_r   <= '0;
            par_r   <= 1'b0;
            Sout    <= head_bit(D);
            Sfrm    <= 1'b1;
            Ready   <= 1'b0;
            state_r <= SHIFT;
          end else begin
            Ready <= 1'b1;
            Sout  <= 1'b0;
            Sfrm  <= 1'b0;
          end
        end
        SHIFT: begin
          shift_r <= shifted_s;
          par_r   <= par_nxt_s;
          cnt_r   <= cnt_r + CW'(1'b1);
          if (cnt_r == LAST_BIT) begin
            state_r <= GAP;
            Sfrm    <= 1'b0;
            Sout    <= 1'b0;
            Done    <= 1'b1;
          end else if (cnt_r == LAST_DATA) begin
            // Only reachable with parity enabled: the next bit is the parity bit.
            Sout <= par_nxt_s;
          end else begin
            Sout <= head_bit(shifted_s);
          end
        end
        GAP: begin
          Done    <= 1'b0;
          Ready   <= 1'b1;
          Sout    <= 1'b0;
          Sfrm    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          Ready   <= 1'b1;
          Sout    <= 1'b0;
          Sfrm    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB-first, MSB-first and parity instances checked
// every cycle against a frame-list reference model.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic [2:0] ld;
  logic [2:0] rdy, sout, sfrm, done;

  int vectors;
  int miscompares;

  // Reference model state per instance: 0 = LSB first, 1 = MSB first, 2 = parity.
  int         msb_p [3] = '{0, 1, 0};
  int         par_p [3] = '{0, 0, 1};
  logic [8:0] fr    [3];
  int         flen  [3];
  int         fpos  [3];
  bit         act   [3];
  bit         gp    [3];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY(0)) u_lsb (
    .Clk(clk), .Rst(rst), .D(d), .Load(ld[0]),
    .Ready(rdy[0]), .Sout(sout[0]), .Sfrm(sfrm[0]), .Done(done[0]));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY(0)) u_msb (
    .Clk(clk), .Rst(rst), .D(d), .Load(ld[1]),
    .Ready(rdy[1]), .Sout(sout[1]), .Sfrm(sfrm[1]), .Done(done[1]));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY(1)) u_par (
    .Clk(clk), .Rst(rst), .D(d), .Load(ld[2]),
    .Ready(rdy[2]), .Sout(sout[2]), .Sfrm(sfrm[2]), .Done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        act[i] = 1'b0;
        gp[i]  = 1'b0;
      end else if (act[i]) begin
        fpos[i]++;
        if (fpos[i] == flen[i]) begin
          act[i] = 1'b0;
          gp[i]  = 1'b1;
        end
      end else if (gp[i]) begin
        gp[i] = 1'b0;
      end else if (ld[i]) begin
        fr[i] = '0;
        for (int b = 0; b < 8; b++) begin
          fr[i][b] = (msb_p[i] != 0) ? d[7-b] : d[b];
        end
        flen[i] = 8;
        if (par_p[i] != 0) begin
          fr[i][8] = $countones(d) % 2;
          flen[i] = 9;
        end
        fpos[i] = 0;
        act[i]  = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("ready%0d", i), 32'(rdy[i]), 32'(!act[i] && !gp[i]));
      check_eq($sformatf("sfrm%0d", i), 32'(sfrm[i]), 32'(act[i]));
      check_eq($sformatf("sout%0d", i), 32'(sout[i]), act[i] ? 32'(fr[i][fpos[i]]) : 32'd0);
      check_eq($sformatf("done%0d", i), 32'(done[i]), 32'(gp[i]));
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [7:0] cap_l, cap_m;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0; gp[i] = 1'b0; fpos[i] = 0; flen[i] = 8; fr[i] = '0;
    end

    // Reset with Load asserted: no frame may start.
    rst = 1'b1; ld = 3'b111; d = 8'hFF;
    idle_ticks(2);
    rst = 1'b0; ld = 3'b000;
    idle_ticks(2);

    // LSB- and MSB-first frames of 1E, also captured as explicit bit patterns.
    d = 8'h1E; ld = 3'b111;
    tick();
    ld = 3'b000;
    for (int i = 0; i < 8; i++) begin
      cap_l[i] = sout[0];
      cap_m[i] = sout[1];
      tick();
    end
    check_eq("lsb_1e_bits", 32'(cap_l), 32'h1E);
    check_eq("msb_1e_bits", 32'(cap_m), 32'h78);
    idle_ticks(3);

    // Parity frames: 07 gives parity 1, 1E gives parity 0.
    d = 8'h07; ld = 3'b100; tick(); ld = 3'b000; idle_ticks(12);
    d = 8'h1E; ld = 3'b100; tick(); ld = 3'b000; idle_ticks(12);

    // Load and D changes mid-frame are ignored.
    d = 8'hA5; ld = 3'b111; tick(); ld = 3'b000;
    idle_ticks(3);
    d = 8'h00; ld = 3'b111; tick(); ld = 3'b000;
    idle_ticks(12);

    // Load held high: back-to-back frames.
    ld = 3'b111;
    for (int k = 0; k < 32; k++) begin
      d = 8'($urandom);
      tick();
    end
    ld = 3'b000;
    idle_ticks(12);

    // Reset during bit 4 abandons the frame; a fresh 3C frame follows.
    d = 8'h3C; ld = 3'b111; tick(); ld = 3'b000;
    idle_ticks(4);
    rst = 1'b1; tick(); rst = 1'b0;
    idle_ticks(2);
    d = 8'h3C; ld = 3'b111; tick(); ld = 3'b000;
    idle_ticks(12);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      d   = 8'($urandom);
      ld  = 3'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; ld = 3'b000;
    idle_ticks(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
